rx_tlp_trigger_mp: RTL and testbench
====================================

Name: rx_tlp_trigger_mp

Overview:
Parametrised successor of the RX TLP trigger. Watches the committed write pointer of the on-chip RX ring and decides when to emit full-size DMA TLPs toward host huge pages. Also decides when a timeout flush sends a short final TLP, and when the current huge page is closed. Generalised to N host huge pages in round-robin, with configurable TLP size, page size, header reserve and timeouts; TLPs are only issued into a page the host has marked available.

Parameters:
BF, 9, ring address MSB; pointers are [BF:0], ring depth 2^(BF+1) qwords
MAX_TLP_QW, 16, qwords per full TLP; power of 2, ≤ 2^BF
HP_QW_LOG2, 18, log2 of huge-page size in qwords (18 = 2 MB)
HDR_QW, 16, qwords reserved at start of each page; multiple of MAX_TLP_QW
NUM_HP, 2, number of host huge pages, ≥2
TO_LONG, 'hA000, idle cycles before flush when not all pages available
TO_SHORT, 'h10, idle cycles before flush when all pages available

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
commited_wr_address  in  BF+1  ring write pointer (qwords)
commited_rd_address  out  BF+1  ring read pointer, advanced per acked TLP
trigger_tlp  out  1  full TLP request, held until ack
trigger_tlp_ack  in  1  TLP accepted
send_last_tlp  out  1  short final TLP + page close request, held until change_huge_page_ack
change_huge_page  out  1  close page without data, held until ack
change_huge_page_ack  in  1  ack for send_last_tlp or change_huge_page
qwords_to_send  out  $clog2(MAX_TLP_QW)+1  payload size of current request
huge_page_status  in  NUM_HP  bit i = host page i available
hp_index  out  $clog2(NUM_HP)  current page

Behaviour:
- Reset: all outputs 0; rd ptr 0; hp_index 0; page fill hp_qw = HDR_QW; dirty 0; FSM IDLE; timeout counter 0.
- diff = (wr − rd) mod 2^(BF+1), registered every cycle (one-cycle lag; FSM uses registered value).
- Timeout counter: increments only in IDLE, cleared in any other state. Timeout is a one-cycle pulse at count == TO_LONG, or at count == TO_SHORT when &huge_page_status.
- room = 2^HP_QW_LOG2 − hp_qw (HP_QW_LOG2+1 bits). Invariant: room is 0 or ≥ MAX_TLP_QW.
- IDLE:
  - if !huge_page_status[hp_index], stay in IDLE; no request is issued, the timer still runs.
  - else if diff ≥ MAX_TLP_QW: latch n = diff / MAX_TLP_QW; go to EVAL.
  - else if timeout && dirty: go to CLOSE.
  - else if timeout && diff ≠ 0: go to LAST with qwords_to_send = diff.
- EVAL:
  - room == 0 → CLOSE.
  - else: qwords_to_send = MAX_TLP_QW, trigger_tlp = 1, dirty = 1, sent = 0 → SEND.
- SEND: hold trigger_tlp. On ack: drop it → COMMIT.
- COMMIT: rd += qwords_to_send, hp_qw += qwords_to_send, sent++ → NEXT.
- NEXT:
  - sent < n and room ≠ 0: re-assert trigger_tlp → SEND.
  - room == 0 → CLOSE.
  - otherwise → IDLE.
- CLOSE: change_huge_page = 1; on ack drop it → ADV.
- LAST: send_last_tlp = 1, dirty = 1; on change_huge_page_ack drop it, rd += qwords_to_send → ADV.
- ADV: hp_index = (hp_index + 1) mod NUM_HP; hp_qw = HDR_QW; dirty = 0 → IDLE.
- Acks arriving in a state that does not wait for them are ignored. Only one request output is high at a time.
- Pointer wrap is mod 2^(BF+1). A full ring (diff = 2^(BF+1) − … ) is handled by the unsigned diff, with no special case.
- Reset mid-handshake: all requests drop immediately; the requester must discard the in-flight request.

Optional Feature:
- Macro: RX_TLP_TRIG_STATS_EN. When defined, three ports are added, all reset to 0 and wrapping at 2^32:
  - tlp_count [31:0]: incremented in COMMIT.
  - page_count [31:0]: incremented in ADV.
  - flush_count [31:0]: incremented on entry to LAST.
- When undefined, the ports and counters are absent and core behaviour is identical.

Test Plan:
- Defaults, status = 2'b11, wr 0→48 → three TLPs of 16 with ack after 2 cycles; rd = 48 at end; hp_qw = 64; back to IDLE.
- wr = 5, no further writes, status = 2'b11 → after ~16 idle cycles send_last_tlp with qwords_to_send = 5; after ack rd = 5, hp_index = 1, hp_qw = 16.
- status = 2'b01, dirty page 0, diff = 0 → change_huge_page after TO_LONG cycles; on ack hp_index = 1.
- HP_QW_LOG2 = 6, continuous writes of 64 qwords → 3 TLPs, then change_huge_page, hp_index 0→1, remaining data goes to page 1.
- huge_page_status[hp_index] = 0 with diff = 32 → no trigger_tlp. Raising the bit → two TLPs issued.
- wr wrap: BF = 4, rd = 24, wr = 8 → diff = 16 → one TLP; rd wraps to 8.

Source files
------------

// File: rtl/rx_tlp_trigger_mp.sv
// rtl/rx_tlp_trigger_mp.sv - RX ring to host huge-page DMA TLP trigger, N pages round-robin
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   commited_wr_address   ring write pointer in qwords (in)
//   commited_rd_address   ring read pointer, advanced per completed request (out)
//   trigger_tlp / _ack    full-size TLP request and its acknowledge
//   send_last_tlp         short final TLP plus page close, acked by change_huge_page_ack
//   change_huge_page      close the current page without data, acked by change_huge_page_ack
//   qwords_to_send        payload size of the current request
//   huge_page_status      bit i set when host page i is available
//   hp_index              page currently being filled
// Optional feature macro RX_TLP_TRIG_STATS_EN adds tlp_count, page_count, flush_count.
module rx_tlp_trigger_mp #(
  parameter int BF         = 9,
  parameter int MAX_TLP_QW = 16,
  parameter int HP_QW_LOG2 = 18,
  parameter int HDR_QW     = 16,
  parameter int NUM_HP     = 2,
  parameter int TO_LONG    = 'hA000,
  parameter int TO_SHORT   = 'h10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [BF:0]                   commited_wr_address,
  output logic [BF:0]                   commited_rd_address,
  output logic                          trigger_tlp,
  input  logic                          trigger_tlp_ack,
  output logic                          send_last_tlp,
  output logic                          change_huge_page,
  input  logic                          change_huge_page_ack,
  output logic [$clog2(MAX_TLP_QW):0]   qwords_to_send,
  input  logic [NUM_HP-1:0]             huge_page_status,
  output logic [$clog2(NUM_HP)-1:0]     hp_index
`ifdef RX_TLP_TRIG_STATS_EN
  ,
  output logic [31:0]                   tlp_count,
  output logic [31:0]                   page_count,
  output logic [31:0]                   flush_count
`endif
);

  localparam int QW_W = $clog2(MAX_TLP_QW) + 1;
  localparam int HI_W = $clog2(NUM_HP);
  localparam int HP_W = HP_QW_LOG2 + 1;
  localparam int SH   = $clog2(MAX_TLP_QW);

  localparam logic [HP_W-1:0] HP_SIZE = HP_W'(1) << HP_QW_LOG2;
  localparam logic [HP_W-1:0] HDR_P   = HP_W'(HDR_QW);
  localparam logic [BF:0]     MAX_P   = (BF+1)'(MAX_TLP_QW);
  localparam logic [QW_W-1:0] MAX_Q   = QW_W'(MAX_TLP_QW);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_SEND, S_COMMIT, S_NEXT, S_CLOSE, S_LAST, S_ADV
  } state_t;

  state_t          state, next_state;
  logic [BF:0]     diff_q;
  logic [BF:0]     n_q;
  logic [BF:0]     sent_q;
  logic [HP_W-1:0] hp_qw;
  logic [HP_W-1:0] room;
  logic            dirty;
  logic [31:0]     to_cnt;
  logic            timeout;

  assign room    = HP_SIZE - hp_qw;
  // Short timeout only when the host has every page ready; otherwise wait long
  // so partially filled pages are not closed while the host is still catching up.
  assign timeout = (to_cnt == 32'(TO_LONG)) ||
                   ((&huge_page_status) && (to_cnt == 32'(TO_SHORT)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state       = state;
    trigger_tlp      = 1'b0;
    send_last_tlp    = 1'b0;
    change_huge_page = 1'b0;
    case (state)
      S_IDLE: begin
        if (!huge_page_status[hp_index])   next_state = S_IDLE;
        else if (diff_q >= MAX_P)          next_state = S_EVAL;
        else if (timeout && dirty)         next_state = S_CLOSE;
        else if (timeout && diff_q != '0)  next_state = S_LAST;
      end
      S_EVAL:   next_state = (room == '0) ? S_CLOSE : S_SEND;
      S_SEND: begin
        trigger_tlp = 1'b1;
        if (trigger_tlp_ack) next_state = S_COMMIT;
      end
      S_COMMIT: next_state = S_NEXT;
      S_NEXT: begin
        if (sent_q < n_q && room != '0) next_state = S_SEND;
        else if (room == '0)            next_state = S_CLOSE;
        else                            next_state = S_IDLE;
      end
      S_CLOSE: begin
        change_huge_page = 1'b1;
        if (change_huge_page_ack) next_state = S_ADV;
      end
      S_LAST: begin
        send_last_tlp = 1'b1;
        if (change_huge_page_ack) next_state = S_ADV;
      end
      S_ADV:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff_q              <= '0;
      n_q                 <= '0;
      sent_q              <= '0;
      hp_qw               <= HDR_P;
      dirty               <= 1'b0;
      to_cnt              <= '0;
      qwords_to_send      <= '0;
      commited_rd_address <= '0;
      hp_index            <= '0;
    end else begin
      // One-cycle lag on the fill level; every decision uses this registered copy.
      diff_q <= commited_wr_address - commited_rd_address;
      to_cnt <= (state == S_IDLE) ? to_cnt + 32'd1 : 32'd0;
      case (state)
        S_IDLE: begin
          if (next_state == S_EVAL) n_q <= diff_q >> SH;
          if (next_state == S_LAST) begin
            qwords_to_send <= QW_W'(diff_q);
            dirty          <= 1'b1;
          end
        end
        S_EVAL: begin
          if (next_state == S_SEND) begin
            qwords_to_send <= MAX_Q;
            dirty          <= 1'b1;
            sent_q         <= '0;
          end
        end
        S_COMMIT: begin
          commited_rd_address <= commited_rd_address + (BF+1)'(qwords_to_send);
          hp_qw               <= hp_qw + HP_W'(qwords_to_send);
          sent_q              <= sent_q + (BF+1)'(1);
        end
        S_LAST: begin
          if (change_huge_page_ack)
            commited_rd_address <= commited_rd_address + (BF+1)'(qwords_to_send);
        end
        S_ADV: begin
          hp_index <= (hp_index == HI_W'(NUM_HP-1)) ? '0 : hp_index + HI_W'(1);
          hp_qw    <= HDR_P;
          dirty    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef RX_TLP_TRIG_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tlp_count   <= '0;
      page_count  <= '0;
      flush_count <= '0;
    end else begin
      if (state == S_COMMIT) tlp_count <= tlp_count + 32'd1;
      if (state == S_ADV)    page_count <= page_count + 32'd1;
      if (state == S_IDLE && next_state == S_LAST) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_tlp_trigger_mp.sv
// tb/tb_rx_tlp_trigger_mp.sv - directed bench for rx_tlp_trigger_mp (three parameter sets)
module tb_rx_tlp_trigger_mp;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // dut0: default parameters
  logic [9:0] wr0, rd0;
  logic       trig0, tack0 = 1'b0, last0, chg0, cack0 = 1'b0;
  logic [4:0] qw0;
  logic [1:0] st0;
  logic [0:0] hp0;
  int ntlp0 = 0, nchg0 = 0, nlast0 = 0, lastq0 = -1, badqw0 = 0, dly0 = 0;

  // dut1: 64-qword pages
  logic [9:0] wr1, rd1;
  logic       trig1, tack1 = 1'b0, last1, chg1, cack1 = 1'b0;
  logic [4:0] qw1;
  logic [1:0] st1;
  logic [0:0] hp1;
  int ntlp1 = 0, nchg1 = 0, ntlp1_p1 = 0, closerd1 = -1, dly1 = 0;

  // dut2: 32-qword ring
  logic [4:0] wr2, rd2;
  logic       trig2, tack2 = 1'b0, last2, chg2, cack2 = 1'b0;
  logic [4:0] qw2;
  logic [1:0] st2;
  logic [0:0] hp2;
  int ntlp2 = 0, nchg2 = 0, nlast2 = 0, lastq2 = -1, dly2 = 0;

  rx_tlp_trigger_mp u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .commited_wr_address(wr0), .commited_rd_address(rd0),
    .trigger_tlp(trig0), .trigger_tlp_ack(tack0),
    .send_last_tlp(last0), .change_huge_page(chg0), .change_huge_page_ack(cack0),
    .qwords_to_send(qw0), .huge_page_status(st0), .hp_index(hp0)
  );

  rx_tlp_trigger_mp #(.HP_QW_LOG2(6)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .commited_wr_address(wr1), .commited_rd_address(rd1),
    .trigger_tlp(trig1), .trigger_tlp_ack(tack1),
    .send_last_tlp(last1), .change_huge_page(chg1), .change_huge_page_ack(cack1),
    .qwords_to_send(qw1), .huge_page_status(st1), .hp_index(hp1)
  );

  rx_tlp_trigger_mp #(.BF(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .commited_wr_address(wr2), .commited_rd_address(rd2),
    .trigger_tlp(trig2), .trigger_tlp_ack(tack2),
    .send_last_tlp(last2), .change_huge_page(chg2), .change_huge_page_ack(cack2),
    .qwords_to_send(qw2), .huge_page_status(st2), .hp_index(hp2)
  );

  // Host-side responders: ack each request on the second falling edge it is seen.
  initial forever begin
    @(negedge clk);
    if (tack0 || cack0) begin tack0 = 1'b0; cack0 = 1'b0; dly0 = 0; end
    else if (trig0 || last0 || chg0) begin
      dly0++;
      if (dly0 == 2) begin
        if (trig0) begin tack0 = 1'b1; ntlp0++; if (qw0 != 5'd16) badqw0++; end
        else begin
          cack0 = 1'b1;
          if (last0) begin nlast0++; lastq0 = int'(qw0); end else nchg0++;
        end
      end
    end else dly0 = 0;
  end

  initial forever begin
    @(negedge clk);
    if (tack1 || cack1) begin tack1 = 1'b0; cack1 = 1'b0; dly1 = 0; end
    else if (trig1 || last1 || chg1) begin
      dly1++;
      if (dly1 == 2) begin
        if (trig1) begin tack1 = 1'b1; ntlp1++; if (hp1 == 1'b1) ntlp1_p1++; end
        else begin cack1 = 1'b1; if (chg1) begin nchg1++; closerd1 = int'(rd1); end end
      end
    end else dly1 = 0;
  end

  initial forever begin
    @(negedge clk);
    if (tack2 || cack2) begin tack2 = 1'b0; cack2 = 1'b0; dly2 = 0; end
    else if (trig2 || last2 || chg2) begin
      dly2++;
      if (dly2 == 2) begin
        if (trig2) begin tack2 = 1'b1; ntlp2++; end
        else begin
          cack2 = 1'b1;
          if (last2) begin nlast2++; lastq2 = int'(qw2); end else nchg2++;
        end
      end
    end else dly2 = 0;
  end

  initial begin
    int el;
    reset_n = 1'b0;
    wr0 = '0; st0 = 2'b00;
    wr1 = '0; st1 = 2'b00;
    wr2 = '0; st2 = 2'b00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_rd", rd0, 0);
    check("rst_hp", hp0, 0);
    check("rst_trig", trig0, 0);
    check("rst_last", last0, 0);
    check("rst_chg", chg0, 0);
    check("rst_qw", qw0, 0);

    // Three full TLPs from 48 qwords, then a dirty-page close on the short timeout.
    st0 = 2'b11; wr0 = 10'd48;
    for (int i = 0; i < 200 && rd0 != 10'd48; i++) @(negedge clk);
    check("t1_rd", rd0, 48);
    check("t1_ntlp", ntlp0, 3);
    check("t1_hp", hp0, 0);
    for (int i = 0; i < 100 && hp0 != 1'b1; i++) @(negedge clk);
    check("t1_close", nchg0, 1);
    check("t1_hp_adv", hp0, 1);

    // Five stray qwords on a clean page: short final TLP after the short timeout.
    wr0 = 10'd53;
    for (int i = 0; i < 100 && rd0 != 10'd53; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t2_nlast", nlast0, 1);
    check("t2_lastq", lastq0, 5);
    check("t2_rd", rd0, 53);
    check("t2_hp", hp0, 0);

    // Not all pages available: dirty page closes only after the long timeout.
    st0 = 2'b01; wr0 = 10'd69;
    for (int i = 0; i < 100 && rd0 != 10'd69; i++) @(negedge clk);
    check("t3_ntlp", ntlp0, 4);
    el = 0;
    repeat (100) begin @(negedge clk); el++; end
    check("t3_no_early_close", nchg0, 1);
    while (el < 42000 && !chg0) begin @(negedge clk); el++; end
    check("t3_long_to", (el >= 40950 && el <= 40975) ? 1 : 0, 1);
    for (int i = 0; i < 20 && hp0 != 1'b1; i++) @(negedge clk);
    check("t3_close", nchg0, 2);
    check("t3_hp", hp0, 1);

    // Page 1 unavailable: 32 qwords wait; raising its bit releases two TLPs.
    wr0 = 10'd101;
    repeat (50) @(negedge clk);
    check("t5_gated_ntlp", ntlp0, 4);
    check("t5_gated_rd", rd0, 69);
    st0 = 2'b11;
    for (int i = 0; i < 100 && rd0 != 10'd101; i++) @(negedge clk);
    check("t5_ntlp", ntlp0, 6);
    check("t5_rd", rd0, 101);
    check("t5_qw16", badqw0, 0);

    // 64-qword pages: 3 TLPs fill page 0, close, 4th TLP lands on page 1.
    st1 = 2'b11; wr1 = 10'd64;
    for (int i = 0; i < 300 && rd1 != 10'd64; i++) @(negedge clk);
    check("t4_rd", rd1, 64);
    check("t4_ntlp", ntlp1, 4);
    check("t4_nchg", nchg1, 1);
    check("t4_close_rd", closerd1, 48);
    check("t4_hp", hp1, 1);
    check("t4_p1_tlp", ntlp1_p1, 1);

    // 32-qword ring: reach rd = 24, then wr = 8 gives diff 16 and rd wraps to 8.
    st2 = 2'b11; wr2 = 5'd24;
    for (int i = 0; i < 100 && rd2 != 5'd16; i++) @(negedge clk);
    check("t6_rd16", rd2, 16);
    for (int i = 0; i < 200 && rd2 != 5'd24; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t6_rd24", rd2, 24);
    check("t6_lastq", lastq2, 8);
    check("t6_nchg", nchg2, 1);
    check("t6_hp", hp2, 0);
    wr2 = 5'd8;
    for (int i = 0; i < 100 && rd2 != 5'd8; i++) @(negedge clk);
    check("t6_wrap_rd", rd2, 8);
    check("t6_ntlp", ntlp2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
